// File: rtl/abs_phase_src_arbiter.sv
// Round-robin arbiter that feeds one absolute-phase calculator from NUM_SRC wrapped-phase AXIS sources.
// Each grant covers GROUP_PKTS whole lines and checks that they all have the same length.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; scan requesters from rr_ptr, register the winner
// XFER  | granted source passed through until its group's last tlast
module abs_phase_src_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int GROUP_PKTS = 3,
  parameter int MAX_BEATS  = 4096,
  localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [SRC_W-1:0]              m_axis_tid,
  output logic                          busy,
  output logic                          group_done,
  output logic                          len_err
);

  localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int PKT_W = (GROUP_PKTS > 1) ? $clog2(GROUP_PKTS) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(MAX_BEATS - 1);
  localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(GROUP_PKTS - 1);
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NUM_SRC - 1);

  logic [0:0]       state;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] grant;
  logic [PKT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W:0]   ref_len;

  logic             pick_found;
  logic [SRC_W-1:0] pick_idx;
  logic [SRC_W-1:0] cand;
  logic             xfer;
  logic             beat_acc;
  logic             last_pkt;
  logic [CNT_W:0]   line_len;
  logic [SRC_W-1:0] rr_next;

  assign xfer     = (state == XFER);
  assign busy     = xfer;
  assign beat_acc = m_axis_tvalid & m_axis_tready;
  assign last_pkt = (pkt_cnt == PKT_LAST);
  // One wider than beat_cnt so a saturated line still compares correctly.
  assign line_len = {1'b0, beat_cnt} + (CNT_W + 1)'(1);
  assign rr_next  = (grant == SRC_LAST) ? '0 : grant + SRC_W'(1);
  assign m_axis_tid = grant;

  // Rotating priority scan starting at rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = SRC_W'((int'(rr_ptr) + i) % NUM_SRC);
      if (!pick_found && s_axis_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // tvalid/tready follow the grant only in XFER; all other sources see tready=0.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (grant == SRC_W'(k)) begin
        m_axis_tdata = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        if (xfer) begin
          m_axis_tvalid    = s_axis_tvalid[k];
          m_axis_tlast     = s_axis_tlast[k];
          s_axis_tready[k] = m_axis_tready;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      grant      <= '0;
      pkt_cnt    <= '0;
      beat_cnt   <= '0;
      ref_len    <= '0;
      group_done <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      group_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick_idx;
            state <= XFER;
          end
        end
        XFER: begin
          if (beat_acc) begin
            if (m_axis_tlast) begin
              beat_cnt <= '0;
              // The first line of a group sets the reference length.
              if (pkt_cnt == '0) begin
                ref_len <= line_len;
              end else if (line_len != ref_len) begin
                len_err <= 1'b1;
              end
              if (last_pkt) begin
                state      <= IDLE;
                rr_ptr     <= rr_next;
                pkt_cnt    <= '0;
                group_done <= 1'b1;
              end else begin
                pkt_cnt <= pkt_cnt + PKT_W'(1);
              end
            end else if (beat_cnt != BEAT_MAX) begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_abs_phase_src_arbiter.sv
// Directed bench for abs_phase_src_arbiter: per-source beat models feed the DUT and a
// scoreboard tracks per-source output order; each scenario task checks its own results.
module tb_abs_phase_src_arbiter;
  localparam int NS    = 4;
  localparam int DW    = 128;
  localparam int SW    = 2;
  localparam int DEPTH = 64;
  localparam int OUTD  = 256;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [NS*DW-1:0] s_axis_tdata;
  logic [NS-1:0]   s_axis_tvalid;
  logic [NS-1:0]   s_axis_tready;
  logic [NS-1:0]   s_axis_tlast;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic [SW-1:0]   m_axis_tid;
  logic            busy;
  logic            group_done;
  logic            len_err;

  abs_phase_src_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .GROUP_PKTS(3), .MAX_BEATS(4096)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .busy(busy), .group_done(group_done), .len_err(len_err)
  );

  always #5 aclk = ~aclk;

  logic [DW-1:0] src_data [NS][DEPTH];
  logic          src_last [NS][DEPTH];
  int            src_len  [NS];
  int            src_idx  [NS];
  int            exp_ptr  [NS];
  logic [NS-1:0] acc;

  logic [SW-1:0] out_tid  [OUTD];
  logic          out_last [OUTD];
  int out_n, gd_cnt, seq_bad, idle_cnt, err_n, first_beat_cyc;
  int gd_at [8];
  logic tv0, busy0;
  int vec = 0;
  int errs = 0;

  function automatic logic [DW-1:0] mk(input int k, input int s);
    return {32'(k), 32'(s), 32'h5A5A_5A5A, 32'(k * 4096 + s)};
  endfunction

  function automatic bit pending();
    for (int k = 0; k < NS; k++) if (src_idx[k] < src_len[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NS; k++) begin
      src_len[k] = 0;
      src_idx[k] = 0;
      exp_ptr[k] = 0;
    end
    acc = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    out_n = 0; gd_cnt = 0; seq_bad = 0; idle_cnt = 0; err_n = -1; first_beat_cyc = -1;
  endtask

  task automatic load_lines(input int k, input int nbeats, input int nlines);
    for (int l = 0; l < nlines; l++) begin
      for (int b = 0; b < nbeats; b++) begin
        src_data[k][src_len[k]] = mk(k, src_len[k]);
        src_last[k][src_len[k]] = (b == nbeats - 1);
        src_len[k]++;
      end
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    clear_model();
    m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  // Advance sources that handed over a beat; a valid beat is held until it is taken.
  task automatic drive(input bit rnd);
    for (int k = 0; k < NS; k++) begin
      if (acc[k]) src_idx[k]++;
      if (!(s_axis_tvalid[k] && !acc[k])) begin
        if (src_idx[k] < src_len[k]) begin
          s_axis_tvalid[k] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
          s_axis_tdata[k*DW +: DW] = src_data[k][src_idx[k]];
          s_axis_tlast[k] = src_last[k][src_idx[k]];
        end else begin
          s_axis_tvalid[k] = 1'b0;
          s_axis_tlast[k]  = 1'b0;
        end
      end
    end
    acc = '0;
    m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run(input int max_cycles, input int stop_n, input bit rnd);
    int cyc;
    int t;
    bit started;
    cyc = 0;
    started = 1'b0;
    drive(rnd);
    forever begin
      @(negedge aclk);
      if (cyc == 0) begin
        tv0 = m_axis_tvalid;
        busy0 = busy;
      end
      if (len_err && err_n < 0) err_n = out_n;
      if (group_done) begin
        if (gd_cnt < 8) gd_at[gd_cnt] = out_n;
        gd_cnt++;
      end
      if (busy) started = 1'b1;
      else if (started && pending()) idle_cnt++;
      acc = s_axis_tvalid & s_axis_tready;
      if (m_axis_tvalid && m_axis_tready) begin
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
        t = int'(m_axis_tid);
        if (exp_ptr[t] >= src_len[t] || m_axis_tdata !== src_data[t][exp_ptr[t]] ||
            m_axis_tlast !== src_last[t][exp_ptr[t]] || m_axis_tdata[127:96] !== 32'(t))
          seq_bad++;
        exp_ptr[t]++;
        if (out_n < OUTD) begin
          out_tid[out_n]  = m_axis_tid;
          out_last[out_n] = m_axis_tlast;
        end
        out_n++;
      end
      if (stop_n == 0 && !pending() && !busy) break;
      @(posedge aclk);
      #1;
      drive(rnd);
      cyc++;
      if (stop_n > 0 && out_n >= stop_n) break;
      if (cyc >= max_cycles) begin
        vec++; errs++;
        $display("FAIL run_timeout: cycles=%0d beats_out=%0d required completion", cyc, out_n);
        break;
      end
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_axis_tvalid = '1;
    s_axis_tlast  = '1;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    vec++; if (s_axis_tready !== '0) begin errs++; $display("FAIL reset_ready: got %b want 0000", s_axis_tready); end
    vec++; if (m_axis_tvalid !== 1'b0) begin errs++; $display("FAIL reset_mvalid: got %b want 0", m_axis_tvalid); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (len_err !== 1'b0) begin errs++; $display("FAIL reset_len_err: got %b want 0", len_err); end
    vec++; if (group_done !== 1'b0) begin errs++; $display("FAIL reset_group_done: got %b want 0", group_done); end
  endtask

  task automatic test_single_source();
    int bad_tid, bad_last;
    do_reset();
    load_lines(2, 8, 3);
    run(500, 0, 1'b0);
    bad_tid = 0; bad_last = 0;
    for (int i = 0; i < 24; i++) begin
      if (out_tid[i] !== 2'd2) bad_tid++;
      if (out_last[i] !== ((i % 8) == 7)) bad_last++;
    end
    vec++; if (tv0 !== 1'b0) begin errs++; $display("FAIL single_idle_mvalid: got %b want 0", tv0); end
    vec++; if (busy0 !== 1'b0) begin errs++; $display("FAIL single_idle_busy: got %b want 0", busy0); end
    vec++; if (first_beat_cyc != 1) begin errs++; $display("FAIL single_grant_latency: got %0d want 1", first_beat_cyc); end
    vec++; if (out_n != 24) begin errs++; $display("FAIL single_beats: got %0d want 24", out_n); end
    vec++; if (bad_tid != 0) begin errs++; $display("FAIL single_tid: got %0d bad want 0", bad_tid); end
    vec++; if (bad_last != 0) begin errs++; $display("FAIL single_tlast_pos: got %0d bad want 0", bad_last); end
    vec++; if (seq_bad != 0) begin errs++; $display("FAIL single_data: got %0d bad want 0", seq_bad); end
    vec++; if (gd_cnt != 1) begin errs++; $display("FAIL single_group_done: got %0d pulses want 1", gd_cnt); end
    vec++; if (len_err !== 1'b0) begin errs++; $display("FAIL single_len_err: got %b want 0", len_err); end
  endtask

  task automatic test_round_robin();
    int order [5];
    int bad;
    order = '{0, 1, 2, 3, 0};
    do_reset();
    load_lines(0, 4, 6);
    load_lines(1, 4, 3);
    load_lines(2, 4, 3);
    load_lines(3, 4, 3);
    run(1000, 0, 1'b0);
    bad = 0;
    for (int i = 0; i < 60; i++) if (int'(out_tid[i]) != order[i / 12]) bad++;
    vec++; if (out_n != 60) begin errs++; $display("FAIL rr_beats: got %0d want 60", out_n); end
    vec++; if (bad != 0) begin errs++; $display("FAIL rr_grant_order: got %0d bad beats want 0", bad); end
    vec++; if (idle_cnt != 4) begin errs++; $display("FAIL rr_idle_gaps: got %0d want 4", idle_cnt); end
    vec++; if (gd_cnt != 5) begin errs++; $display("FAIL rr_group_done: got %0d want 5", gd_cnt); end
    vec++; if (gd_at[4] != 60) begin errs++; $display("FAIL rr_last_done_pos: got %0d want 60", gd_at[4]); end
    vec++; if (seq_bad != 0) begin errs++; $display("FAIL rr_data: got %0d bad want 0", seq_bad); end
  endtask

  task automatic test_len_err();
    do_reset();
    load_lines(1, 8, 2);
    load_lines(1, 7, 1);
    load_lines(1, 4, 3);
    run(500, 0, 1'b0);
    vec++; if (err_n != 23) begin errs++; $display("FAIL lenerr_set_point: got beats=%0d want 23", err_n); end
    vec++; if (len_err !== 1'b1) begin errs++; $display("FAIL lenerr_sticky: got %b want 1", len_err); end
    vec++; if (gd_cnt != 2) begin errs++; $display("FAIL lenerr_group_done: got %0d want 2", gd_cnt); end
    vec++; if (idle_cnt != 1) begin errs++; $display("FAIL lenerr_regrant_gap: got %0d want 1", idle_cnt); end
    vec++; if (out_n != 35 || seq_bad != 0) begin errs++; $display("FAIL lenerr_data: got beats=%0d bad=%0d want 35/0", out_n, seq_bad); end
  endtask

  task automatic test_random_backpressure();
    int short_src;
    do_reset();
    load_lines(0, 2, 6);
    load_lines(1, 3, 3);
    load_lines(2, 4, 3);
    load_lines(3, 5, 3);
    run(3000, 0, 1'b1);
    short_src = 0;
    for (int k = 0; k < NS; k++) if (exp_ptr[k] != src_len[k]) short_src++;
    vec++; if (out_n != 48) begin errs++; $display("FAIL rand_beats: got %0d want 48", out_n); end
    vec++; if (seq_bad != 0) begin errs++; $display("FAIL rand_data_tid: got %0d bad want 0", seq_bad); end
    vec++; if (short_src != 0) begin errs++; $display("FAIL rand_per_source_count: got %0d short want 0", short_src); end
    vec++; if (gd_cnt != 5) begin errs++; $display("FAIL rand_group_done: got %0d want 5", gd_cnt); end
    vec++; if (len_err !== 1'b0) begin errs++; $display("FAIL rand_len_err: got %b want 0", len_err); end
  endtask

  task automatic test_reset_mid_group();
    do_reset();
    load_lines(1, 2, 3);
    load_lines(3, 8, 3);
    run(500, 18, 1'b0);
    vec++; if (m_axis_tid !== 2'd3 || busy !== 1'b1) begin errs++; $display("FAIL midrst_pre: got tid=%0d busy=%b want 3/1", m_axis_tid, busy); end
    aresetn = 1'b0;
    #1;
    vec++; if (s_axis_tready !== '0 || m_axis_tvalid !== 1'b0) begin errs++; $display("FAIL midrst_outputs: got ready=%b mvalid=%b want 0000/0", s_axis_tready, m_axis_tvalid); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b want 0", busy); end
    clear_model();
    load_lines(0, 4, 3);
    load_lines(3, 4, 3);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    run(500, 0, 1'b0);
    vec++; if (out_tid[0] !== 2'd0 || out_tid[12] !== 2'd3) begin errs++; $display("FAIL midrst_rr_restart: got tids %0d,%0d want 0,3", out_tid[0], out_tid[12]); end
    vec++; if (gd_cnt != 2 || gd_at[0] != 12 || gd_at[1] != 24) begin errs++; $display("FAIL midrst_pkt_restart: got done=%0d at %0d,%0d want 2 at 12,24", gd_cnt, gd_at[0], gd_at[1]); end
    vec++; if (seq_bad != 0 || len_err !== 1'b0) begin errs++; $display("FAIL midrst_data: got bad=%0d len_err=%b want 0/0", seq_bad, len_err); end
  endtask

  initial begin
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    clear_model();
    test_reset();
    test_single_source();
    test_round_robin();
    test_len_err();
    test_random_backpressure();
    test_reset_mid_group();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
